// File: rtl/fphub_stream_accumulator.sv
// fphub_stream_accumulator
//   Sequential accumulation stage wrapped around an external combinational
//   FPHUB adder. The running sum is presented on add_x and the incoming
//   operand on add_y. The adder result add_z is registered back into the
//   accumulator, one add per accepted operand. When the operand flagged
//   last has been absorbed, the stage presents the sum and the element
//   count on a valid/ready output.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    FPHUB operand {sign, exponent, mantissa}
//   in_valid   in_data/in_last valid
//   in_last    marks the final operand of the current sum
//   in_ready   stage accepts an operand this cycle
//   add_x      to adder X: accumulator register
//   add_y      to adder Y: in_data pass-through
//   add_z      from adder Z: X+Y, combinational
//   out_data   final sum
//   out_count  operands accumulated into out_data (saturating)
//   out_valid  out_data/out_count valid
//   out_ready  downstream accepts the result
module fphub_stream_accumulator #(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [E+M:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [E+M:0]     add_x,
  output logic [E+M:0]     add_y,
  input  logic [E+M:0]     add_z,
  output logic [E+M:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int W = E + M + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [W-1:0]     acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             live_reg;
  logic             in_fire;
  logic             out_fire;

  // live_reg keeps in_ready low while reset is asserted, even though the
  // state register already reads IDLE. It rises on the first clock edge
  // after reset is released.
  assign in_ready  = live_reg && (state_reg != DONE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = acc_reg;
  assign out_count = cnt_reg;

  // The adder lives outside this block, in the feedback path.
  assign add_x = acc_reg;
  assign add_y = in_data;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Once the counter is all ones it stays there, but the sum keeps
  // absorbing operands.
  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (in_fire) begin
          // The first operand loads directly. The adder output is unused
          // because the accumulator holds no valid partial sum yet.
          acc_next   = in_data;
          cnt_next   = CNT_W'(1);
          state_next = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_next   = add_z;
          cnt_next   = cnt_inc;
          state_next = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_fire) begin
          // The accumulator is left as is. The next first operand overwrites it.
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      live_reg  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fphub_stream_accumulator.sv
module tb_fphub_stream_accumulator;

  localparam int M     = 23;
  localparam int E     = 8;
  localparam int CNT_W = 4;   // small counter so saturation is reachable quickly
  localparam int W     = E + M + 1;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [W-1:0]     add_x, add_y;
  logic [W-1:0]     add_z;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  int z_mode  = 0;   // 0: integer mock adder, 1: junk constant, 2: FPHUB adder model

  always #5 clk = ~clk;

  fphub_stream_accumulator #(.M(M), .E(E), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_x(add_x), .add_y(add_y), .add_z(add_z),
    .out_data(out_data), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  // FPHUB add for the equal-sign, equal-exponent case. Each significand is
  // 1.m plus the implicit HUB half-ulp, and the result is renormalised by
  // one place.
  function automatic logic [31:0] fphub_add(input logic [31:0] a, input logic [31:0] b);
    logic [25:0] s;
    if (a[31] == b[31] && a[30:23] == b[30:23]) begin
      s = {1'b0, 1'b1, a[22:0], 1'b1} + {1'b0, 1'b1, b[22:0], 1'b1};
      return {a[31], a[30:23] + 8'd1, s[24:2]};
    end
    return a + b;
  endfunction

  always_comb begin
    case (z_mode)
      1:       add_z = 32'hDEADBEEF;
      2:       add_z = fphub_add(add_x, add_y);
      default: add_z = add_x + add_y;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until it is accepted (bounded wait).
  task automatic send(input logic [31:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) tick();
    if (!in_ready) check("send_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  // Check the result one cycle after the last accept. Apply a random stall
  // to out_ready, then drain the result.
  task automatic collect(input string tag, input logic [31:0] exp_d, input int exp_c, input int stall);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"},  64'(out_data),  64'(exp_d));
    check({tag, "_count"}, 64'(out_count), 64'(exp_c));
    for (int k = 0; k < stall; k++) begin
      tick();
      check({tag, "_hold"}, {31'd0, out_valid, in_ready, out_data},
            {31'd0, 1'b1, 1'b0, exp_d});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] sum;
    int          len;

    // Check the reset state.
    #2;
    check("rst_outs", {out_valid, in_ready, out_data, 4'(out_count)}, 38'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", 64'(in_ready), 64'd1);

    // 1: Single element. The adder output must be ignored in IDLE.
    z_mode = 1;
    send(32'h3F800000, 1'b1);
    z_mode = 0;
    collect("t1", 32'h3F800000, 1, 0);

    // 2: Three elements back to back.
    check("t2_ready0", 64'(in_ready), 64'd1);
    send(32'h1, 1'b0);
    check("t2_ready1", {out_valid, in_ready}, 2'b01);
    send(32'h2, 1'b0);
    check("t2_ready2", {out_valid, in_ready}, 2'b01);
    send(32'h3, 1'b1);
    collect("t2", 32'h6, 3, 0);

    // 3: Backpressure for five cycles.
    send(32'h7, 1'b0);
    send(32'h9, 1'b1);
    collect("t3", 32'h10, 2, 5);

    // 4: Gaps in in_valid. A stray in_last without in_valid must be ignored.
    send(32'h10, 1'b0);
    in_last = 1'b1;
    tick();
    tick();
    in_last = 1'b0;
    check("t4_gap_state", {out_valid, in_ready}, 2'b01);
    send(32'h20, 1'b1);
    collect("t4", 32'h30, 2, 0);

    // 5: Reset after two of four operands.
    send(32'h100, 1'b0);
    send(32'h200, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst", {out_valid, in_ready, out_data, 4'(out_count)}, 38'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(32'h5, 1'b1);
    collect("t5", 32'h5, 1, 0);

    // Reset while in DONE: out_valid drops without a clock edge.
    send(32'h44, 1'b1);
    check("t5b_done", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5b_async_drop", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 6: FPHUB adder in the loop, 1.0 + 1.0 = 2.0.
    z_mode = 2;
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    z_mode = 0;
    collect("t6", 32'h40000000, 2, 0);

    // Counter saturation: 18 operands, count pins at SAT, sum keeps going.
    sum = 0;
    for (int i = 1; i <= 18; i++) begin
      send(32'(i), i == 18);
      sum += 32'(i);
    end
    collect("sat", sum, SAT, 0);

    // Random sums checked against a queue-based reference.
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(1, 20);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back($urandom);
      sum = 0;
      foreach (q[i]) sum += q[i];
      for (int i = 0; i < len; i++) begin
        send(q[i], i == len - 1);
        if (i != len - 1) begin
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      collect("rand", sum, (len > SAT) ? SAT : len, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
